// File: rtl/cpu_bus_sequencer.sv
// 8088-style bus-cycle master: turns single requests into T1..T4 status/address/data
// activity for an 8288-style bus controller, stretching T3 with TW states on ready.
module cpu_bus_sequencer #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_write_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_timeout,
  output logic [19:0] cpu_address,
  output logic [7:0]  cpu_data_bus,
  output logic        cpu_data_out_enable,
  output logic [2:0]  processor_status,
  output logic        processor_lock_n,
  input  logic        processor_ready,
  input  logic [7:0]  data_bus
);

  typedef enum logic [2:0] {
    S_TI,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4,
    S_TI_INTA
  } state_t;

  localparam logic [2:0] ST_INTA    = 3'b000;
  localparam logic [2:0] ST_IOR     = 3'b001;
  localparam logic [2:0] ST_IOW     = 3'b010;
  localparam logic [2:0] ST_HALT    = 3'b011;
  localparam logic [2:0] ST_CODE    = 3'b100;
  localparam logic [2:0] ST_MEMR    = 3'b101;
  localparam logic [2:0] ST_MEMW    = 3'b110;
  localparam logic [2:0] ST_PASSIVE = 3'b111;
  localparam logic [4:0] WAIT_LIMIT = 5'(MAX_WAIT);

  state_t      state;
  logic [2:0]  cur_type;
  logic        inta_second;
  logic [4:0]  wait_count;

  logic        accept;
  logic        req_is_write;
  logic        cur_is_read;
  logic        inta_first;
  logic        cycle_timeout;
  logic        cycle_done;
  logic [7:0]  finish_data;

  assign accept       = req_valid & req_ready;
  assign req_is_write = (req_type == ST_IOW) || (req_type == ST_MEMW);
  assign cur_is_read  = (cur_type == ST_INTA) || (cur_type == ST_IOR) ||
                        (cur_type == ST_CODE) || (cur_type == ST_MEMR);
  assign inta_first   = (cur_type == ST_INTA) && !inta_second;

  // HALT never waits; any other cycle ends on ready or when the wait budget is spent.
  assign cycle_timeout = !processor_ready && (cur_type != ST_HALT) &&
                         (wait_count >= WAIT_LIMIT);
  assign cycle_done    = (cur_type == ST_HALT) || processor_ready || cycle_timeout;

  always_comb begin
    finish_data = 8'h00;
    if (cycle_timeout) begin
      finish_data = 8'hFF;
    end else if (cur_is_read) begin
      finish_data = data_bus;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_TI;
      cur_type            <= ST_PASSIVE;
      inta_second         <= 1'b0;
      wait_count          <= 5'd0;
      req_ready           <= 1'b0;
      rsp_valid           <= 1'b0;
      rsp_data            <= 8'h00;
      rsp_timeout         <= 1'b0;
      cpu_address         <= 20'h00000;
      cpu_data_bus        <= 8'h00;
      cpu_data_out_enable <= 1'b0;
      processor_status    <= ST_PASSIVE;
      processor_lock_n    <= 1'b1;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        // T4 doubles as an accept slot so back-to-back cycles skip TI.
        S_TI, S_T4: begin
          if (accept && (req_type == ST_PASSIVE)) begin
            state               <= S_TI;
            req_ready           <= 1'b1;
            rsp_valid           <= 1'b1;
            rsp_data            <= 8'hFF;
            processor_status    <= ST_PASSIVE;
            cpu_address         <= 20'h00000;
            cpu_data_bus        <= 8'h00;
            cpu_data_out_enable <= 1'b0;
          end else if (accept) begin
            state               <= S_T1;
            cur_type            <= req_type;
            inta_second         <= 1'b0;
            wait_count          <= 5'd0;
            req_ready           <= 1'b0;
            processor_status    <= req_type;
            cpu_address         <= req_address;
            cpu_data_bus        <= req_is_write ? req_write_data : 8'h00;
            cpu_data_out_enable <= req_is_write;
          end else if ((state == S_T4) && inta_first) begin
            state     <= S_TI_INTA;
            req_ready <= 1'b0;
          end else begin
            state               <= S_TI;
            req_ready           <= 1'b1;
            processor_status    <= ST_PASSIVE;
            cpu_address         <= 20'h00000;
            cpu_data_bus        <= 8'h00;
            cpu_data_out_enable <= 1'b0;
          end
        end
        S_TI_INTA: begin
          state            <= S_T1;
          inta_second      <= 1'b1;
          wait_count       <= 5'd0;
          processor_status <= ST_INTA;
        end
        S_T1: begin
          state <= S_T2;
          if (inta_first) begin
            processor_lock_n <= 1'b0;
          end
        end
        S_T2: begin
          state <= S_T3;
          if (inta_second) begin
            processor_lock_n <= 1'b1;
          end
        end
        // The first INTA cycle ends silently; only the vector cycle responds.
        S_T3, S_TW: begin
          if (cycle_done) begin
            state            <= S_T4;
            processor_status <= ST_PASSIVE;
            rsp_valid        <= !inta_first;
            rsp_timeout      <= cycle_timeout && !inta_first;
            rsp_data         <= finish_data;
            req_ready        <= !inta_first;
          end else begin
            state      <= S_TW;
            wait_count <= wait_count + 5'd1;
          end
        end
        default: begin
          state <= S_TI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Randomized bench for cpu_bus_sequencer: a cycle timeline built from bus-cycle rules
// predicts every output for each clock, and each scenario task compares against it.
module tb_cpu_bus_sequencer;

  localparam int MAX_WAIT = 16;
  localparam logic [2:0] INTA    = 3'b000;
  localparam logic [2:0] IOR     = 3'b001;
  localparam logic [2:0] IOW     = 3'b010;
  localparam logic [2:0] HALT    = 3'b011;
  localparam logic [2:0] CODE    = 3'b100;
  localparam logic [2:0] MEMR    = 3'b101;
  localparam logic [2:0] MEMW    = 3'b110;
  localparam logic [2:0] ILLEGAL = 3'b111;

  // Observation vector: {req_ready, rsp_valid, rsp_data, rsp_timeout, cpu_address,
  // cpu_data_bus, cpu_data_out_enable, processor_status, processor_lock_n}
  localparam logic [43:0] FULL     = '1;
  localparam logic [43:0] NO_RSP   = ~(44'h1FF << 33);
  localparam logic [43:0] NO_RDATA = ~(44'hFF << 34);
  localparam logic [43:0] NO_ADDR  = ~(44'hFFFFF << 13);
  localparam logic [43:0] NO_RR    = ~(44'h1 << 43);
  localparam int          SCHED_MAX = 2048;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_type = 3'b000;
  logic [19:0] req_address = 20'h0;
  logic [7:0]  req_write_data = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_timeout;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_data_bus;
  logic        cpu_data_out_enable;
  logic [2:0]  processor_status;
  logic        processor_lock_n;
  logic        processor_ready = 1'b0;
  logic [7:0]  data_bus = 8'h00;

  cpu_bus_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_type            (req_type),
    .req_address         (req_address),
    .req_write_data      (req_write_data),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .rsp_timeout         (rsp_timeout),
    .cpu_address         (cpu_address),
    .cpu_data_bus        (cpu_data_bus),
    .cpu_data_out_enable (cpu_data_out_enable),
    .processor_status    (processor_status),
    .processor_lock_n    (processor_lock_n),
    .processor_ready     (processor_ready),
    .data_bus            (data_bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid_in;
    logic [2:0]  type_in;
    logic [19:0] addr_in;
    logic [7:0]  wdata_in;
    logic        ready_in;
    logic [7:0]  dbus_in;
    logic [43:0] exp;
    logic [43:0] mask;
  } cyc_t;

  cyc_t        sched [0:SCHED_MAX-1];
  logic [43:0] obs_log [0:SCHED_MAX-1];
  int          n_cyc = 0;
  bit          last_inta = 1'b0;
  int          checks = 0;
  int          passed = 0;

  function automatic logic [43:0] pack(input logic rr, input logic rv, input logic [7:0] rd,
                                       input logic rt, input logic [19:0] a, input logic [7:0] db,
                                       input logic oe, input logic [2:0] st, input logic lk);
    return {rr, rv, rd, rt, a, db, oe, st, lk};
  endfunction

  function automatic logic [43:0] sample();
    return {req_ready, rsp_valid, rsp_data, rsp_timeout, cpu_address, cpu_data_bus,
            cpu_data_out_enable, processor_status, processor_lock_n};
  endfunction

  function automatic void new_schedule();
    n_cyc     = 0;
    last_inta = 1'b0;
  endfunction

  function automatic void add_cycle(input logic [43:0] e, input logic [43:0] m);
    if (n_cyc < SCHED_MAX) begin
      sched[n_cyc].valid_in = 1'b0;
      sched[n_cyc].type_in  = 3'($urandom_range(0, 7));
      sched[n_cyc].addr_in  = 20'($urandom);
      sched[n_cyc].wdata_in = 8'($urandom);
      sched[n_cyc].ready_in = 1'($urandom);
      sched[n_cyc].dbus_in  = 8'($urandom);
      sched[n_cyc].exp      = e;
      sched[n_cyc].mask     = m;
      n_cyc++;
    end
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++)
      add_cycle(pack(1'b1, 1'b0, 8'h00, 1'b0, 20'h0, 8'h00, 1'b0, 3'b111, 1'b1), NO_RSP);
  endfunction

  // One bus cycle: 3+W active cycles then T4. phase 0 = plain, 1 = first INTA, 2 = second INTA.
  function automatic void add_phase(input logic [2:0] t, input logic [19:0] a, input logic [7:0] wd,
                                    input int waits, input int phase, input int forced);
    logic        wr, rd, to, lk, rr, rv;
    logic [7:0]  db, rdat;
    logic [43:0] m;
    int          w, first;
    wr    = (t == IOW) || (t == MEMW);
    rd    = (t == INTA) || (t == IOR) || (t == CODE) || (t == MEMR);
    db    = wr ? wd : 8'h00;
    to    = (waits < 0) && (t != HALT);
    w     = (t == HALT) ? 0 : (to ? MAX_WAIT : waits);
    first = n_cyc;
    for (int k = 1; k <= 3 + w; k++) begin
      lk = !((phase == 1 && k >= 2) || (phase == 2 && k <= 2));
      add_cycle(pack(1'b0, 1'b0, 8'h00, 1'b0, a, db, wr, t, lk), NO_RSP);
      if (t != HALT && k >= 3) sched[n_cyc-1].ready_in = (k == 3 + w) && !to;
    end
    if (to) begin
      rdat = 8'hFF;
    end else if (rd) begin
      if (forced >= 0) sched[first+2+w].dbus_in = 8'(forced);
      rdat = sched[first+2+w].dbus_in;
    end else begin
      rdat = 8'h00;
    end
    rv = (phase != 1);
    rr = (phase == 0);
    m  = rv ? FULL : NO_RSP;
    if (rv && wr) m = m & NO_RDATA;
    if (phase == 2) m = m & NO_RR;
    add_cycle(pack(rr, rv, rdat, to && rv, a, db, wr, 3'b111, phase != 1), m);
  endfunction

  function automatic void add_txn(input logic [2:0] t, input logic [19:0] a, input logic [7:0] wd,
                                  input int waits, input bit b2b, input int forced);
    int last;
    if (!b2b || n_cyc == 0 || last_inta) add_idle(1);
    last = n_cyc - 1;
    sched[last].valid_in = 1'b1;
    sched[last].type_in  = t;
    sched[last].addr_in  = a;
    sched[last].wdata_in = wd;
    if (t == ILLEGAL) begin
      add_cycle(pack(1'b1, 1'b1, 8'hFF, 1'b0, 20'h0, 8'h00, 1'b0, 3'b111, 1'b1), FULL);
    end else if (t == INTA) begin
      add_phase(INTA, a, wd, waits, 1, -1);
      add_cycle(pack(1'b0, 1'b0, 8'h00, 1'b0, 20'h0, 8'h00, 1'b0, 3'b111, 1'b0), NO_RSP & NO_ADDR);
      add_phase(INTA, a, wd, waits, 2, forced);
    end else begin
      add_phase(t, a, wd, waits, 0, forced);
    end
    last_inta = (t == INTA);
  endfunction

  task automatic play();
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge clock);
      obs_log[i]      = sample();
      req_valid       = sched[i].valid_in;
      req_type        = sched[i].type_in;
      req_address     = sched[i].addr_in;
      req_write_data  = sched[i].wdata_in;
      processor_ready = sched[i].ready_in;
      data_bus        = sched[i].dbus_in;
    end
  endtask

  task automatic test_reset();
    logic [43:0] obs;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    obs = sample();
    checks++;
    if (obs !== pack(1'b0, 1'b0, 8'h00, 1'b0, 20'h0, 8'h00, 1'b0, 3'b111, 1'b1))
      $display("[TB] FAIL reset_values: observed %h expected %h", obs,
               pack(1'b0, 1'b0, 8'h00, 1'b0, 20'h0, 8'h00, 1'b0, 3'b111, 1'b1));
    else passed++;
    reset_n = 1'b1;
    @(negedge clock);
    obs = sample();
    checks++;
    if (obs !== pack(1'b1, 1'b0, 8'h00, 1'b0, 20'h0, 8'h00, 1'b0, 3'b111, 1'b1))
      $display("[TB] FAIL reset_release_ready: observed %h expected %h", obs,
               pack(1'b1, 1'b0, 8'h00, 1'b0, 20'h0, 8'h00, 1'b0, 3'b111, 1'b1));
    else passed++;
  endtask

  task automatic test_ior();
    int active;
    new_schedule();
    add_txn(IOR, 20'h00062, 8'h00, 0, 1'b0, 'hCC);
    add_idle(2);
    for (int i = 0; i < n_cyc; i++) begin
      sched[i].ready_in = 1'b1;
      sched[i].dbus_in  = 8'hCC;
    end
    play();
    active = 0;
    for (int i = 0; i < n_cyc; i++) begin
      if (obs_log[i][3:1] != 3'b111) active++;
      checks++;
      if ((obs_log[i] & sched[i].mask) !== (sched[i].exp & sched[i].mask))
        $display("[TB] FAIL ior cycle %0d: observed %h expected %h mask %h", i, obs_log[i], sched[i].exp, sched[i].mask);
      else passed++;
    end
    checks++;
    if (active !== 3) $display("[TB] FAIL ior_active_cycles: observed %0d expected 3", active);
    else passed++;
  endtask

  task automatic test_memw();
    new_schedule();
    add_txn(MEMW, 20'hB8000, 8'h01, 0, 1'b0, -1);
    add_idle(2);
    play();
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if ((obs_log[i] & sched[i].mask) !== (sched[i].exp & sched[i].mask))
        $display("[TB] FAIL memw cycle %0d: observed %h expected %h mask %h", i, obs_log[i], sched[i].exp, sched[i].mask);
      else passed++;
    end
  endtask

  task automatic test_memr_waits();
    new_schedule();
    add_txn(MEMR, 20'h23456, 8'h00, 3, 1'b0, -1);
    add_idle(2);
    play();
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if ((obs_log[i] & sched[i].mask) !== (sched[i].exp & sched[i].mask))
        $display("[TB] FAIL memr_waits cycle %0d: observed %h expected %h mask %h", i, obs_log[i], sched[i].exp, sched[i].mask);
      else passed++;
    end
    checks++;
    if (obs_log[7][42] !== 1'b1) $display("[TB] FAIL memr_rsp_at_n7: observed %b expected 1", obs_log[7][42]);
    else passed++;
  endtask

  task automatic test_timeout();
    new_schedule();
    add_txn(MEMR, 20'($urandom), 8'h00, -1, 1'b0, -1);
    add_idle(2);
    play();
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if ((obs_log[i] & sched[i].mask) !== (sched[i].exp & sched[i].mask))
        $display("[TB] FAIL timeout cycle %0d: observed %h expected %h mask %h", i, obs_log[i], sched[i].exp, sched[i].mask);
      else passed++;
    end
    checks++;
    if (obs_log[20][42:33] !== {1'b1, 8'hFF, 1'b1})
      $display("[TB] FAIL timeout_rsp_at_n20: observed %h expected 3ff", obs_log[20][42:33]);
    else passed++;
  endtask

  task automatic test_inta();
    int responses;
    new_schedule();
    add_txn(INTA, 20'($urandom), 8'h00, 0, 1'b0, 'h62);
    add_idle(2);
    play();
    responses = 0;
    for (int i = 0; i < n_cyc; i++) begin
      if (obs_log[i][42] === 1'b1) responses++;
      checks++;
      if ((obs_log[i] & sched[i].mask) !== (sched[i].exp & sched[i].mask))
        $display("[TB] FAIL inta cycle %0d: observed %h expected %h mask %h", i, obs_log[i], sched[i].exp, sched[i].mask);
      else passed++;
    end
    checks++;
    if (responses !== 1) $display("[TB] FAIL inta_response_count: observed %0d expected 1", responses);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int halt_start;
    new_schedule();
    add_txn(IOW, 20'($urandom), 8'($urandom), 0, 1'b0, -1);
    halt_start = n_cyc;
    add_txn(HALT, 20'($urandom), 8'h00, 0, 1'b1, -1);
    for (int i = halt_start; i < n_cyc; i++) sched[i].ready_in = 1'b0;
    add_idle(2);
    play();
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if ((obs_log[i] & sched[i].mask) !== (sched[i].exp & sched[i].mask))
        $display("[TB] FAIL back_to_back cycle %0d: observed %h expected %h mask %h", i, obs_log[i], sched[i].exp, sched[i].mask);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_cycle();
    int          halt_start;
    logic [43:0] obs;
    logic [43:0] rst_vec;
    logic [43:0] idle_vec;
    rst_vec  = pack(1'b0, 1'b0, 8'h00, 1'b0, 20'h0, 8'h00, 1'b0, 3'b111, 1'b1);
    idle_vec = pack(1'b1, 1'b0, 8'h00, 1'b0, 20'h0, 8'h00, 1'b0, 3'b111, 1'b1);
    new_schedule();
    add_txn(IOW, 20'($urandom), 8'($urandom), 0, 1'b0, -1);
    halt_start = n_cyc;
    add_txn(HALT, 20'($urandom), 8'h00, 0, 1'b1, -1);
    for (int i = halt_start; i < n_cyc; i++) sched[i].ready_in = 1'b0;
    n_cyc = halt_start + 2;
    play();
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if ((obs_log[i] & sched[i].mask) !== (sched[i].exp & sched[i].mask))
        $display("[TB] FAIL reset_mid cycle %0d: observed %h expected %h mask %h", i, obs_log[i], sched[i].exp, sched[i].mask);
      else passed++;
    end
    req_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    obs = sample();
    checks++;
    if (obs !== rst_vec) $display("[TB] FAIL reset_mid_async: observed %h expected %h", obs, rst_vec);
    else passed++;
    @(negedge clock);
    obs = sample();
    checks++;
    if (obs !== rst_vec) $display("[TB] FAIL reset_mid_held: observed %h expected %h", obs, rst_vec);
    else passed++;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      obs = sample();
      checks++;
      if (obs !== idle_vec) $display("[TB] FAIL reset_mid_after %0d: observed %h expected %h", i, obs, idle_vec);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [2:0] t;
    int         waits;
    new_schedule();
    for (int n = 0; n < 30; n++) begin
      t     = 3'($urandom_range(0, 7));
      waits = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      add_txn(t, 20'($urandom), 8'($urandom), waits, 1'($urandom), -1);
    end
    add_idle(2);
    play();
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if ((obs_log[i] & sched[i].mask) !== (sched[i].exp & sched[i].mask))
        $display("[TB] FAIL random cycle %0d: observed %h expected %h mask %h", i, obs_log[i], sched[i].exp, sched[i].mask);
      else passed++;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_ior();
    test_memw();
    test_memr_waits();
    test_timeout();
    test_inta();
    test_back_to_back();
    test_reset_mid_cycle();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
